addsub_arbiter: RTL
===================

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  synchronous active-low reset; the block uses one clock only.
REQ-002 SHALL have ports: req_valid  in  2  per-requester request; req_ready  out  2  per-requester accept strobe.
REQ-003 SHALL have ports: req_a0, req_b0  in  5 each  requester-0 operands; req_op0  in  1  requester-0 op (0 add, 1 sub).
REQ-004 SHALL have ports: req_a1, req_b1  in  5 each; req_op1  in  1; same meaning for requester 1.
REQ-005 SHALL have ports: rsp_valid  out  1; rsp_ready  in  1; rsp_id  out  1  requester served; rsp_sum  out  5; rsp_cout  out  1; rsp_ov  out  1  signed overflow; busy  out  1  state not IDLE.

Function
REQ-006 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; one operation in flight at a time.
REQ-007 SHALL, in IDLE with any req_valid high, grant one requester, assert its req_ready for that cycle only, capture its operands and op, and enter EXEC.
REQ-008 SHALL grant the sole valid requester; if both are valid, grant the one indicated by the round-robin pointer.
REQ-009 SHALL set the pointer to the non-granted requester after every grant; the pointer resets to 0.
REQ-010 SHALL hold req_ready at 0 in EXEC and RESP, and at 0 in IDLE when no request is valid.
REQ-011 SHALL, in EXEC, compute the result through the core and register sum, cout, ov and id, then enter RESP.
REQ-012 SHALL compute add as A+B with carry-in 0, and sub as A+~B with carry-in 1, all 5-bit two's complement.
REQ-013 SHALL set cout to the raw carry out of bit 4.
REQ-014 SHALL set ov to the XOR of the carry into bit 4 and the carry out of bit 4.
REQ-015 SHALL, in RESP, assert rsp_valid and hold all rsp_* fields stable until rsp_ready is high, then return to IDLE.
REQ-016 SHALL give a latency of accept at cycle t -> rsp_valid at t+2 when rsp_ready is held high; best-case throughput is one op per 3 cycles.
REQ-017 SHALL evaluate a new request in the first IDLE cycle after the RESP handshake, with no dead cycle beyond IDLE.
REQ-018 SHALL ignore req_valid changes during EXEC and RESP; a requester keeps its request asserted until it sees req_ready.

Reset
REQ-019 SHALL, while rst_n is low at a clk edge, force state IDLE, pointer 0, req_ready 0, rsp_valid 0, rsp_id 0, rsp_sum 0, rsp_cout 0, rsp_ov 0 and busy 0.
REQ-020 SHALL discard any in-flight operation on reset mid-EXEC or mid-RESP, producing no response afterwards.

Configuration
REQ-021 SHALL provide macro ADDSUB_ARBITER_SAT_EN.
REQ-022 SHALL, with ADDSUB_ARBITER_SAT_EN defined, replace rsp_sum on ov=1 with 01111 for a positive true result or 10000 for a negative one, while rsp_ov and rsp_cout still report raw values.
REQ-023 SHALL, with ADDSUB_ARBITER_SAT_EN undefined, output the wrapped sum and include no saturation logic.

Structure
REQ-024 SHALL place in a shared package addsub_pkg: WIDTH=5, an op enum (OP_ADD, OP_SUB), the FSM state enum and a result struct (sum, cout, ov).
REQ-025 SHALL instantiate a single combinational sub-module, addsub5_core (a, b, op -> sum, cout, ov, c4), which owns the operand inversion and carry-in selection.

Verification
REQ-026 SHALL cover: req0 add 00110+00001 -> rsp_sum 00111, cout 0, ov 0, id 0, rsp_valid 2 cycles after accept.
REQ-027 SHALL cover: req1 add 00010+01111 -> sum 10001, ov 1, cout 0; with SAT_EN -> sum 01111, ov 1.
REQ-028 SHALL cover: req0 sub 00010-10000 -> sum 10010, ov 1, cout 0; and sub 00110-00010 -> sum 00100, cout 1, ov 0.
REQ-029 SHALL cover: both valid from reset -> req0 granted first, then req1, alternating over 4 consecutive ops with no starvation.
REQ-030 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_* stable and req_ready 0 throughout; rsp_ready pulse -> IDLE next cycle.
REQ-031 SHALL cover: rst_n low during EXEC -> all outputs 0 next cycle, no response delivered, and the pointer selects req0 on the next contention.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types for the add/sub arbiter: operand width, op and FSM encodings,
// result bundle and the saturation limits used when ADDSUB_ARBITER_SAT_EN is defined.
package addsub_pkg;

    localparam int WIDTH = 5;

    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ov;
    } result_t;

endpackage

// File: rtl/addsub5_core.sv
// Purpose: WIDTH-bit two's complement add/sub, exposing carry into and out of the MSB.
// Latency: purely combinational.
// Backpressure: none; output follows the operands.
module addsub5_core
    import addsub_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ov,
    output logic             c4
);

    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic [WIDTH-1:0] lo;
    logic [1:0]       hi;

    // Split the adder at the MSB so the carry into the sign bit is visible for ov.
    always_comb begin
        cin   = (op == OP_SUB);
        b_eff = cin ? ~b : b;
        lo    = {1'b0, a[WIDTH-2:0]} + {1'b0, b_eff[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, cin};
        c4    = lo[WIDTH-1];
        hi    = {1'b0, a[WIDTH-1]} + {1'b0, b_eff[WIDTH-1]} + {1'b0, c4};
        sum   = {hi[0], lo[WIDTH-2:0]};
        cout  = hi[1];
        ov    = c4 ^ cout;
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Purpose: round-robin arbiter for two requesters sharing one add/sub core (ADDSUB_ARBITER_SAT_EN saturates rsp_sum on overflow).
// Latency: accept in cycle t, rsp_valid in t+2; one op in flight, best case one op per 3 cycles.
// Backpressure: req_ready only in IDLE; rsp_* held stable in RESP until rsp_ready.
module addsub_arbiter
    import addsub_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic             req_op0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic             req_op1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_ov,
    output logic             busy
);

    state_e           state;
    logic             ptr;
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;
    op_e              cap_op;
    logic             cap_id;
    result_t          rsp_q;

    logic             gnt_vld;
    logic             gnt_id;
    logic [WIDTH-1:0] core_sum;
    logic             core_cout;
    logic             core_ov;
    logic             core_c4;
    result_t          core_res;

    always_comb begin
        gnt_vld = |req_valid;
        gnt_id  = (req_valid == 2'b11) ? ptr : req_valid[1];
    end

    // Combinational so the accept lands in the same IDLE cycle the grant is made.
    always_comb begin
        req_ready = 2'b00;
        if (rst_n && (state == ST_IDLE) && gnt_vld)
            req_ready = gnt_id ? 2'b10 : 2'b01;
    end

    addsub5_core u_core (
        .a    (cap_a),
        .b    (cap_b),
        .op   (cap_op),
        .sum  (core_sum),
        .cout (core_cout),
        .ov   (core_ov),
        .c4   (core_c4)
    );

    always_comb begin
        core_res.cout = core_cout;
        core_res.ov   = core_ov;
`ifdef ADDSUB_ARBITER_SAT_EN
        // On overflow the wrapped sign is the inverse of the true sign.
        if (core_ov)
            core_res.sum = core_sum[WIDTH-1] ? SAT_POS : SAT_NEG;
        else
            core_res.sum = core_sum;
`else
        core_res.sum  = core_sum;
`endif
        ov_matches_carries: assert (core_ov == (core_c4 ^ core_cout));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= 1'b0;
            cap_a     <= '0;
            cap_b     <= '0;
            cap_op    <= OP_ADD;
            cap_id    <= 1'b0;
            rsp_q     <= '0;
            rsp_id    <= 1'b0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        cap_a  <= gnt_id ? req_a1 : req_a0;
                        cap_b  <= gnt_id ? req_b1 : req_b0;
                        cap_op <= gnt_id ? op_e'(req_op1) : op_e'(req_op0);
                        cap_id <= gnt_id;
                        ptr    <= ~gnt_id;
                        busy   <= 1'b1;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_q     <= core_res;
                    rsp_id    <= cap_id;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_sum  = rsp_q.sum;
    assign rsp_cout = rsp_q.cout;
    assign rsp_ov   = rsp_q.ov;

endmodule
